pipelined_rca: RTL and testbench
================================

Name: pipelined_rca

Overview:
Parametrised, pipelined successor to the single-bit full adder. Adds or subtracts two WIDTH-bit operands by rippling carry through STAGES equal-width segments, with the carry registered between segments. Operand and result skew registers align the chunks. A valid/ready handshake with backpressure sits on both sides, so the block drops into the ALU datapath as an elastic pipeline stage.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline segments; each segment covers SEG = WIDTH/STAGES bits; 1 <= STAGES <= WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands and op presented
in_ready  output  1  block accepts when in_valid && in_ready
x  input  WIDTH  operand A
y  input  WIDTH  operand B
sub  input  1  0: x+y+c_in; 1: x+~y+1 (c_in ignored)
c_in  input  1  carry-in for add
out_valid  output  1  result valid
out_ready  input  1  downstream accepts when out_valid && out_ready
s  output  WIDTH  sum/difference
c_out  output  1  carry-out of MSB (for sub: 1 = no borrow)

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; no asynchronous reset anywhere.
- Reset: all stage valid bits = 0; out_valid = 0; s = 0; c_out = 0; in_ready = 1 on the first cycle after reset deasserts.
- Pipeline advance: adv = !out_valid || out_ready. When adv = 0, every stage register holds (global stall). in_ready = adv.
- Latency: a transfer accepted in cycle N appears on out_valid/s/c_out in cycle N+STAGES, absent stalls. Throughput is 1 result per cycle when out_ready is held high.
- Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] of x and y_eff using the carry registered by stage k-1. Stage 0 carry-in = sub ? 1 : c_in. y_eff = sub ? ~y : y, inverted at the input.
- Upper operand chunks ride in skew registers until their stage. Lower result chunks ride in deskew registers so all of s emerges in one cycle.
- Per-stage valid bit travels with the data. Bubbles are not compressed: an empty slot stalls along with the others.
- Arithmetic is modulo 2^WIDTH. c_out is the carry out of bit WIDTH-1.
- Simultaneous events:
  - in_valid with adv = 1 while the last stage is handshaking: both transfers occur in the same cycle.
  - in_valid with adv = 0: no accept. Upstream must hold x, y, sub and c_in stable until accepted.
- out_valid, s and c_out hold stable while out_valid && !out_ready.
- rst mid-operation: all in-flight results are discarded, and no partial result is ever presented.
- STAGES = 1: a pure registered adder with latency 1.

Optional Feature:
Macro RCA_PIPE_OVF_EN.
- Defined: adds output port ovf (1 bit), the signed two's-complement overflow of the result. ovf = carry into MSB XOR carry out of MSB, with the sub/add interpretation applied. It is aligned with s, is reset to 0, and holds under stall.
- Not defined: the port is absent and no overflow logic is generated.

Decomposition:
- Package rca_pkg: typedef enum logic {OP_ADD=0, OP_SUB=1} rca_op_e; localparam function seg_width(WIDTH, STAGES); elaboration assertion that WIDTH % STAGES == 0.
- Sub-module rca_segment: a combinational SEG-bit ripple segment (inputs a, b, cin; outputs sum, cout). It is built by chaining full_adder cells. pipelined_rca instantiates STAGES of these plus the skew, deskew and valid registers.

Test Plan:
- Reset, then WIDTH=32, STAGES=4: x=0x0000_0001, y=0x0000_0002, c_in=0, sub=0 accepted at cycle 0 -> out_valid at cycle 4, s=0x0000_0003, c_out=0.
- Full carry ripple across every stage: x=0xFFFF_FFFF, y=0x0000_0000, c_in=1 -> s=0x0000_0000, c_out=1 (with RCA_PIPE_OVF_EN: ovf=0).
- Subtract: x=5, y=7, sub=1 -> s=0xFFFF_FFFE, c_out=0 (borrow). Then x=0x8000_0000, y=1, sub=1 -> s=0x7FFF_FFFF, c_out=1, ovf=1.
- Back-to-back stream of 16 random ops with out_ready held at 1 -> one result per cycle, in order, each matching the reference model.
- Backpressure: out_ready=0 for 5 cycles with the pipe full -> in_ready=0, and s/out_valid stay stable. Releasing out_ready -> results drain with no loss or duplication.
- rst asserted for 1 cycle with 3 ops in flight -> next cycle out_valid=0, s=0, c_out=0. A new op accepted afterwards returns its correct result after exactly STAGES cycles.

Source files
------------

// File: rtl/rca_pkg.sv
// Purpose   : shared types and helpers for the pipelined ripple-carry adder.
// Latency   : n/a (package only).
// Backpress.: n/a.
//
// Contents: rca_op_e (add/subtract select), seg_width() (bits per segment).
package rca_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } rca_op_e;

  // Bits handled by each pipeline segment.
  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/rca_segment.sv
// Purpose   : combinational SEG-bit ripple segment built from full_adder cells.
// Latency   : 0 cycles (pure combinational).
// Backpress.: none; the enclosing pipeline owns all flow control.
//
// Ports (rca_segment): a, b [SEG-1:0] operands; cin carry-in;
//                      sum [SEG-1:0] result; cout carry out of bit SEG-1.
// Ports (full_adder) : a, b, cin single-bit inputs; s sum bit; cout carry.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module rca_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  // w_c[i] is the carry into bit i; w_c[SEG] leaves the segment.
  logic [SEG:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < SEG; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_c[i]),
      .s    (sum[i]),
      .cout (w_c[i+1])
    );
  end

  assign cout = w_c[SEG];

endmodule

// File: rtl/pipelined_rca.sv
// Purpose   : elastic WIDTH-bit add/subtract, carry rippled through STAGES registered segments.
// Latency   : STAGES cycles from accept to out_valid when not stalled; 1 result/cycle.
// Backpress.: global stall -- every stage holds while out_valid && !out_ready; in_ready = advance.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready upstream handshake for x, y, sub, c_in
//   x, y [WIDTH-1:0]  operands; sub=1 computes x + ~y + 1 and ignores c_in
//   out_valid/out_ready downstream handshake for s, c_out (and ovf)
//   s [WIDTH-1:0]     sum/difference modulo 2^WIDTH
//   c_out             carry out of bit WIDTH-1 (for subtract, 1 = no borrow)
//   ovf               only when RCA_PIPE_OVF_EN is defined: signed overflow of s
module pipelined_rca
  import rca_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
`ifdef RCA_PIPE_OVF_EN
  output logic             c_out,
  output logic             ovf
`else
  output logic             c_out
`endif
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_chk
    $error("pipelined_rca: WIDTH must be a non-zero multiple of STAGES");
  end

  logic             w_adv;
  rca_op_e          w_op;
  logic [WIDTH-1:0] w_y_eff;
  logic             w_cin0;

  assign w_op    = rca_op_e'(sub);
  assign w_y_eff = (w_op == OP_SUB) ? ~y : y;
  assign w_cin0  = (w_op == OP_SUB) ? 1'b1 : c_in;

  // Bubbles are not squeezed out: one advance signal moves or holds every stage.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Stage k register holds: the valid bit, the carry out of segment k, the
  // result bits produced so far (low (k+1)*SEG bits) and, except in the last
  // stage, the operand bits still waiting for their segment.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DONE_W = (k + 1) * SEG;
    localparam int HI_W   = WIDTH - DONE_W;

    logic [SEG-1:0]    w_a;
    logic [SEG-1:0]    w_b;
    logic [SEG-1:0]    w_sum;
    logic              w_cin;
    logic              w_cout;
    logic              w_vld;
    logic [DONE_W-1:0] w_s_nxt;

    logic              r_vld;
    logic              r_c;
    logic [DONE_W-1:0] r_s;

    if (k == 0) begin : g_src
      assign w_a     = x[SEG-1:0];
      assign w_b     = w_y_eff[SEG-1:0];
      assign w_cin   = w_cin0;
      assign w_vld   = in_valid;
      assign w_s_nxt = w_sum;
    end else begin : g_src
      assign w_a     = g_stage[k-1].g_hi.r_a_hi[SEG-1:0];
      assign w_b     = g_stage[k-1].g_hi.r_b_hi[SEG-1:0];
      assign w_cin   = g_stage[k-1].r_c;
      assign w_vld   = g_stage[k-1].r_vld;
      assign w_s_nxt = {w_sum, g_stage[k-1].r_s};
    end

    rca_segment #(
      .SEG (SEG)
    ) u_seg (
      .a    (w_a),
      .b    (w_b),
      .cin  (w_cin),
      .sum  (w_sum),
      .cout (w_cout)
    );

    // Valid moves on every advance; data only loads behind a real transfer so
    // the output word stays put across bubbles.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_s   <= '0;
      end else if (w_adv) begin
        r_vld <= w_vld;
        if (w_vld) begin
          r_c <= w_cout;
          r_s <= w_s_nxt;
        end
      end
    end

    // Skew registers: upper operand chunks wait here until their segment.
    if (k < STAGES - 1) begin : g_hi
      logic [HI_W-1:0] w_a_hi;
      logic [HI_W-1:0] w_b_hi;
      logic [HI_W-1:0] r_a_hi;
      logic [HI_W-1:0] r_b_hi;

      if (k == 0) begin : g_hsrc
        assign w_a_hi = x[WIDTH-1:SEG];
        assign w_b_hi = w_y_eff[WIDTH-1:SEG];
      end else begin : g_hsrc
        assign w_a_hi = g_stage[k-1].g_hi.r_a_hi[HI_W+SEG-1:SEG];
        assign w_b_hi = g_stage[k-1].g_hi.r_b_hi[HI_W+SEG-1:SEG];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_a_hi <= '0;
          r_b_hi <= '0;
        end else if (w_adv && w_vld) begin
          r_a_hi <= w_a_hi;
          r_b_hi <= w_b_hi;
        end
      end
    end

`ifdef RCA_PIPE_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit, so the segment
    // needs no extra port. b already carries the subtract inversion.
    if (k == STAGES - 1) begin : g_ovf
      logic w_c_msb;
      logic r_ovf;

      assign w_c_msb = w_a[SEG-1] ^ w_b[SEG-1] ^ w_sum[SEG-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_adv && w_vld) begin
          r_ovf <= w_c_msb ^ w_cout;
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[STAGES-1].r_vld;
  assign s         = g_stage[STAGES-1].r_s;
  assign c_out     = g_stage[STAGES-1].r_c;
`ifdef RCA_PIPE_OVF_EN
  assign ovf       = g_stage[STAGES-1].g_ovf.r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_rca.sv
// Purpose   : self-checking bench for pipelined_rca (WIDTH=32, STAGES=4).
// Latency   : checks STAGES-cycle latency plus one cycle per global stall.
// Backpress.: drives out_ready low to fill and hold the pipe, then drains it.
module tb_pipelined_rca;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             sub;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
`ifdef RCA_PIPE_OVF_EN
  logic             ovf;
`endif

  pipelined_rca #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .sub       (sub),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
`ifdef RCA_PIPE_OVF_EN
    .c_out     (c_out),
    .ovf       (ovf)
`else
    .c_out     (c_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        v;
    int          acc;
    int          st;
  } exp_t;

  exp_t q[$];
  int   out_cyc[$];
  int   n_err = 0;
  int   n_chk = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  int   n_out = 0;

  logic        have_hold = 1'b0;
  logic [31:0] hold_s;
  logic        hold_c;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's meaning.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic op, input logic ci);
    exp_t   e;
    longint ua, ub, sa, sb, sr;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op) begin
      e.s = 32'(ua - ub);
      e.c = (ua >= ub);
      sr  = sa - sb;
    end else begin
      e.s = 32'(ua + ub + longint'(ci));
      e.c = ((ua + ub + longint'(ci)) > 64'h0000_0000_FFFF_FFFF);
      sr  = sa + sb + longint'(ci);
    end
    e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.acc = 0;
    e.st  = 0;
    return e;
  endfunction

  // Compare process: runs every cycle, half a period away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
      have_hold = 1'b0;
    end else begin
      if (have_hold) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_s", 64'(s), 64'(hold_s));
        chk("hold_cout", 64'(c_out), 64'(hold_c));
        have_hold = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("stream_s", 64'(s), 64'(e.s));
          chk("stream_cout", 64'(c_out), 64'(e.c));
`ifdef RCA_PIPE_OVF_EN
          chk("stream_ovf", 64'(ovf), 64'(e.v));
`endif
          chk("stream_latency", 64'(cyc - e.acc), 64'(STAGES + stall_cnt - e.st));
        end
        n_out++;
        out_cyc.push_back(cyc);
      end else if (out_valid) begin
        have_hold = 1'b1;
        hold_s    = s;
        hold_c    = c_out;
        stall_cnt++;
      end
      if (in_valid && in_ready) begin
        e     = model(x, y, sub, c_in);
        e.acc = cyc;
        e.st  = stall_cnt;
        q.push_back(e);
      end
    end
  end

  // Present one op from posedge+1 and return at posedge+1 after it transfers.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic op, input logic ci);
    int t;
    x = a; y = b; sub = op; c_in = ci; in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_one(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic ci,
                        input logic [31:0] es, input logic ec, input logic ev);
    int n;
    send(a, b, op, ci);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk({name, "_latency"}, 64'(n), 64'(STAGES));
    chk({name, "_s"}, 64'(s), 64'(es));
    chk({name, "_cout"}, 64'(c_out), 64'(ec));
`ifdef RCA_PIPE_OVF_EN
    chk({name, "_ovf"}, 64'(ovf), 64'(ev));
`else
    if (ev === 1'bx) chk({name, "_ovf_x"}, 64'(ev), 64'd0);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk({name, "_drained"}, 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    int   base;
    int   t;

    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; sub = 1'b0; c_in = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_cout", 64'(c_out), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef RCA_PIPE_OVF_EN
    chk("rst_ovf", 64'(ovf), 64'd0);
`endif

    // Pin the reference model with hand-derived values.
    e = model(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
    chk("model_sub_s", 64'(e.s), 64'h7FFF_FFFF);
    chk("model_sub_c", 64'(e.c), 64'd1);
    chk("model_sub_v", 64'(e.v), 64'd1);
    e = model(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
    chk("model_ripple_s", 64'(e.s), 64'd0);
    chk("model_ripple_c", 64'(e.c), 64'd1);

    // Directed ops with hand-computed results.
    do_one("add_1_2",    32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
    do_one("ripple",     32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    do_one("sub_5_7",    32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_one("sub_min_1",  32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    do_one("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

    // Back-to-back stream of 16 random ops, out_ready held high.
    base = out_cyc.size();
    for (int i = 0; i < 16; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain("stream");
    chk("stream_count", 64'(out_cyc.size() - base), 64'd16);
    if (out_cyc.size() - base == 16)
      chk("stream_throughput", 64'(out_cyc[base+15] - out_cyc[base]), 64'd15);

    // Backpressure: fill the pipe with out_ready low, hold 5 cycles, release.
    base = n_out;
    out_ready = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    x = 32'h0000_00FF; y = 32'h0000_0001; sub = 1'b0; c_in = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_release_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain("bp");
    chk("bp_count", 64'(n_out - base), 64'(STAGES + 1));

    // Reset with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      send($urandom, $urandom, 1'b0, 1'b0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_s", 64'(s), 64'd0);
    chk("midrst_cout", 64'(c_out), 64'd0);
    repeat (STAGES + 1) begin
      @(negedge clk);
      chk("midrst_no_ghost", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    do_one("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 1'b0, 1'b0);

    drain("final");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
